// File: rtl/coherence_bus_ctrl_if.sv
// coherence_bus_ctrl_if: request, snoop and memory signals of the MESI bus.
// master = bus controller, slave = L1 caches plus the memory port.
interface coherence_bus_ctrl_if #(
    parameter int N_CACHES = 2,
    parameter int ADDR_W   = 32,
    parameter int WORD_W   = 32
);
    logic [N_CACHES-1:0]        req_valid;
    logic [N_CACHES-1:0]        req_write;
    logic [N_CACHES*ADDR_W-1:0] req_addr;
    logic [N_CACHES-1:0]        snoop_req;
    logic [ADDR_W-1:0]          snoop_addr;
    logic                       snoop_inv;
    logic [N_CACHES-1:0]        snoop_resp_valid;
    logic [N_CACHES-1:0]        snoop_hit;
    logic [N_CACHES-1:0]        snoop_dirty;
    logic [N_CACHES*WORD_W-1:0] snoop_data;
    logic [N_CACHES-1:0]        resp_valid;
    logic [WORD_W-1:0]          resp_data;
    logic [1:0]                 resp_state;
    logic                       mem_ren;
    logic                       mem_wen;
    logic [ADDR_W-1:0]          mem_addr;
    logic [WORD_W-1:0]          mem_wdata;
    logic [WORD_W-1:0]          mem_rdata;
    logic                       mem_ready;

    modport master (
        input  req_valid, req_write, req_addr,
        output snoop_req, snoop_addr, snoop_inv,
        input  snoop_resp_valid, snoop_hit, snoop_dirty, snoop_data,
        output resp_valid, resp_data, resp_state,
        output mem_ren, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output req_valid, req_write, req_addr,
        input  snoop_req, snoop_addr, snoop_inv,
        output snoop_resp_valid, snoop_hit, snoop_dirty, snoop_data,
        input  resp_valid, resp_data, resp_state,
        input  mem_ren, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: snooping MESI controller, N L1 caches to one memory port.
// Ports: CLK, RST (sync, active high), bus (coherence_bus_ctrl_if.master):
//   req_* miss requests, snoop_* snoop handshake, resp_* fill response,
//   mem_* memory port. End state: M=0 E=1 S=2 I=3.
// Optional macro CC_CACHE_TO_CACHE_EN: clean read hits are filled from the
//   lowest-index clean sharer instead of memory.
module coherence_bus_ctrl #(
    parameter int N_CACHES = 2,
    parameter int ADDR_W   = 32,
    parameter int WORD_W   = 32
) (
    input logic                  CLK,
    input logic                  RST,
    coherence_bus_ctrl_if.master bus
);
    localparam int IW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;
    localparam logic [1:0] ST_M = 2'd0;
    localparam logic [1:0] ST_E = 2'd1;
    localparam logic [1:0] ST_S = 2'd2;

    typedef enum logic [2:0] {
        IDLE, SNOOP, DECIDE, WB, MEMRD, C2C, RESP
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       win_q, win_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [N_CACHES-1:0] seen_q, seen_d;
    logic [N_CACHES-1:0] hit_q, hit_d;
    logic [N_CACHES-1:0] dirty_q, dirty_d;
    logic [WORD_W-1:0]   sdata_q [N_CACHES];
    logic [WORD_W-1:0]   sdata_d [N_CACHES];
    logic [WORD_W-1:0]   data_q, data_d;
    logic [1:0]          mesi_q, mesi_d;

    logic [N_CACHES-1:0] win_mask;
    logic [N_CACHES-1:0] snooped;
    logic [N_CACHES-1:0] resp_now;
    logic [IW-1:0]       cand;
    logic [IW-1:0]       rr_idx;
    logic                rr_found;
    logic [IW-1:0]       dsel;
    logic                dfound;
    logic                cfound;
`ifdef CC_CACHE_TO_CACHE_EN
    logic [IW-1:0]       csel;
`endif

    always_comb begin
        win_mask = '0;
        for (int i = 0; i < N_CACHES; i++) begin
            win_mask[i] = (IW'(i) == win_q);
        end
    end

    assign snooped  = ~win_mask;
    // Only the first answer of each snooped cache is taken.
    assign resp_now = bus.snoop_resp_valid & snooped & ~seen_q;

    // Round-robin: first requester at or after the pointer.
    always_comb begin
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 0; k < N_CACHES; k++) begin
            cand = IW'((int'(ptr_q) + k) % N_CACHES);
            if (!rr_found && bus.req_valid[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Descending scan so the lowest index wins.
    always_comb begin
        dsel   = '0;
        dfound = 1'b0;
        cfound = 1'b0;
`ifdef CC_CACHE_TO_CACHE_EN
        csel   = '0;
`endif
        for (int i = N_CACHES - 1; i >= 0; i--) begin
            if (hit_q[i] && dirty_q[i]) begin
                dsel   = IW'(i);
                dfound = 1'b1;
            end
            if (hit_q[i] && !dirty_q[i]) begin
                cfound = 1'b1;
`ifdef CC_CACHE_TO_CACHE_EN
                csel   = IW'(i);
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        seen_d  = seen_q;
        hit_d   = hit_q;
        dirty_d = dirty_q;
        sdata_d = sdata_q;
        data_d  = data_q;
        mesi_d  = mesi_q;

        bus.snoop_req  = '0;
        bus.snoop_addr = '0;
        bus.snoop_inv  = 1'b0;
        bus.resp_valid = '0;
        bus.resp_data  = '0;
        bus.resp_state = '0;
        bus.mem_ren    = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (rr_found) begin
                    win_d   = rr_idx;
                    addr_d  = bus.req_addr[int'(rr_idx)*ADDR_W +: ADDR_W];
                    wr_d    = bus.req_write[rr_idx];
                    seen_d  = '0;
                    hit_d   = '0;
                    dirty_d = '0;
                    state_d = SNOOP;
                end
            end
            SNOOP: begin
                bus.snoop_req  = snooped;
                bus.snoop_addr = addr_q;
                bus.snoop_inv  = wr_q;
                for (int i = 0; i < N_CACHES; i++) begin
                    if (resp_now[i]) begin
                        hit_d[i]   = bus.snoop_hit[i];
                        dirty_d[i] = bus.snoop_dirty[i];
                        sdata_d[i] = bus.snoop_data[i*WORD_W +: WORD_W];
                    end
                end
                seen_d = seen_q | resp_now;
                // Winner counts as answered, so N_CACHES=1 leaves at once.
                if (&(seen_q | resp_now | win_mask)) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                unique case (1'b1)
                    dfound && wr_q: begin
                        data_d  = sdata_q[dsel];
                        mesi_d  = ST_M;
                        state_d = RESP;
                    end
                    dfound && !wr_q: begin
                        data_d  = sdata_q[dsel];
                        mesi_d  = ST_S;
                        state_d = WB;
                    end
                    !dfound && cfound && !wr_q: begin
                        mesi_d  = ST_S;
`ifdef CC_CACHE_TO_CACHE_EN
                        state_d = C2C;
`else
                        state_d = MEMRD;
`endif
                    end
                    default: begin
                        mesi_d  = wr_q ? ST_M : ST_E;
                        state_d = MEMRD;
                    end
                endcase
            end
            WB: begin
                bus.mem_wen   = 1'b1;
                bus.mem_addr  = addr_q;
                bus.mem_wdata = data_q;
                if (bus.mem_ready) begin
                    state_d = RESP;
                end
            end
            MEMRD: begin
                bus.mem_ren  = 1'b1;
                bus.mem_addr = addr_q;
                if (bus.mem_ready) begin
                    data_d  = bus.mem_rdata;
                    state_d = RESP;
                end
            end
`ifdef CC_CACHE_TO_CACHE_EN
            C2C: begin
                data_d  = sdata_q[csel];
                state_d = RESP;
            end
`endif
            RESP: begin
                bus.resp_valid = win_mask;
                bus.resp_data  = data_q;
                bus.resp_state = mesi_q;
                ptr_d = (win_q == IW'(N_CACHES - 1)) ? '0 : win_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            seen_q  <= '0;
            hit_q   <= '0;
            dirty_q <= '0;
            data_q  <= '0;
            mesi_q  <= '0;
            for (int i = 0; i < N_CACHES; i++) begin
                sdata_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            seen_q  <= seen_d;
            hit_q   <= hit_d;
            dirty_q <= dirty_d;
            data_q  <= data_d;
            mesi_q  <= mesi_d;
            for (int i = 0; i < N_CACHES; i++) begin
                sdata_q[i] <= sdata_d[i];
            end
        end
    end

    // Two MODIFIED copies of one block means a cache broke the protocol.
    a_one_owner: assert property (@(posedge CLK) disable iff (RST)
        (state_q == DECIDE) |-> $onehot0(hit_q & dirty_q));

    a_mem_excl: assert property (@(posedge CLK) disable iff (RST)
        !(bus.mem_ren && bus.mem_wen));
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed and random miss traffic for the MESI
// bus controller, checked against a rule-level model of the protocol.
module tb_coherence_bus_ctrl;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int WW = 32;
    localparam logic [1:0] MESI_M = 2'd0;
    localparam logic [1:0] MESI_E = 2'd1;
    localparam logic [1:0] MESI_S = 2'd2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    coherence_bus_ctrl_if #(.N_CACHES(N), .ADDR_W(AW), .WORD_W(WW)) bus ();

    coherence_bus_ctrl #(.N_CACHES(N), .ADDR_W(AW), .WORD_W(WW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int ptr    = 0;

    bit              pend  [N];
    logic [AW-1:0]   paddr [N];
    bit              pwr   [N];
    bit              t_hit   [N];
    bit              t_dirty [N];
    logic [WW-1:0]   t_sd    [N];
    int              t_dly   [N];
    logic [WW-1:0]   t_md;
    int              t_mdly;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = pend[i];
            bus.req_write[i] = pwr[i];
            bus.req_addr[i*AW +: AW] = paddr[i];
        end
    endtask

    task automatic idle_inputs();
        bus.snoop_resp_valid = '0;
        bus.snoop_hit        = '0;
        bus.snoop_dirty      = '0;
        bus.snoop_data       = '0;
        bus.mem_ready        = 1'b0;
        bus.mem_rdata        = '0;
    endtask

    task automatic clear_scn();
        for (int i = 0; i < N; i++) begin
            t_hit[i]   = 1'b0;
            t_dirty[i] = 1'b0;
            t_sd[i]    = '0;
            t_dly[i]   = 0;
        end
        t_md   = '0;
        t_mdly = 0;
    endtask

    function automatic int rr_pick();
        for (int k = 0; k < N; k++) begin
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic all_outs_zero(input string tag);
        chk(tag, {63'd0, |{bus.snoop_req, bus.snoop_addr, bus.snoop_inv,
                 bus.resp_valid, bus.resp_data, bus.resp_state,
                 bus.mem_ren, bus.mem_wen, bus.mem_addr,
                 bus.mem_wdata}}, 64'd0);
    endtask

    // Serve one miss of cache w; the scenario lives in the t_* tables.
    task automatic run_txn(input int w);
        logic [WW-1:0] e_data;
        logic [1:0]    e_state;
        bit            e_wb, e_rd, wr, done, saw_ren, saw_wen, saw_both;
        int            e_lat, maxd, extra, owner, clean, cyc, mcnt;
        int            cnt [N];
        logic [AW-1:0] a, ren_a, wen_a;
        logic [WW-1:0] wen_d;
        logic [N-1:0]  onehot;

        wr = pwr[w];
        a  = paddr[w];
        onehot = '0;
        onehot[w] = 1'b1;
        owner = -1;
        clean = -1;
        maxd  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            cnt[i] = 0;
            if (i != w) begin
                if (t_hit[i] && t_dirty[i]) owner = i;
                if (t_hit[i] && !t_dirty[i]) clean = i;
                if (t_dly[i] > maxd) maxd = t_dly[i];
            end
        end
        e_wb = 1'b0;
        e_rd = 1'b0;
        if (owner >= 0 && !wr) begin
            e_wb = 1'b1; e_data = t_sd[owner];
            e_state = MESI_S; extra = t_mdly + 1;
        end else if (owner >= 0) begin
            e_data = t_sd[owner]; e_state = MESI_M; extra = 0;
        end else if (clean >= 0 && !wr) begin
            e_state = MESI_S;
`ifdef CC_CACHE_TO_CACHE_EN
            e_data = t_sd[clean]; extra = 1;
`else
            e_rd = 1'b1; e_data = t_md; extra = t_mdly + 1;
`endif
        end else begin
            e_rd = 1'b1; e_data = t_md; extra = t_mdly + 1;
            e_state = wr ? MESI_M : MESI_E;
        end
        e_lat = 3 + maxd + extra;

        drive_req();
        done = 1'b0; cyc = 0; mcnt = 0;
        saw_ren = 1'b0; saw_wen = 1'b0; saw_both = 1'b0;
        ren_a = '0; wen_a = '0; wen_d = '0;
        while (!done && cyc < 200) begin
            @(negedge CLK);
            cyc++;
            idle_inputs();
            if (cyc == 1) begin
                chk("snoop_req", {62'd0, bus.snoop_req}, {62'd0, ~onehot});
                chk("snoop_addr", {32'd0, bus.snoop_addr}, {32'd0, a});
                chk("snoop_inv", {63'd0, bus.snoop_inv}, {63'd0, wr});
            end
            for (int i = 0; i < N; i++) begin
                if (bus.snoop_req[i]) begin
                    if (cnt[i] == t_dly[i]) begin
                        bus.snoop_resp_valid[i] = 1'b1;
                        bus.snoop_hit[i]   = t_hit[i];
                        bus.snoop_dirty[i] = t_dirty[i];
                        bus.snoop_data[i*WW +: WW] = t_sd[i];
                    end
                    cnt[i]++;
                end
            end
            if (bus.mem_ren && bus.mem_wen) saw_both = 1'b1;
            if (bus.mem_ren || bus.mem_wen) begin
                if (bus.mem_ren) begin
                    saw_ren = 1'b1; ren_a = bus.mem_addr;
                end else begin
                    saw_wen = 1'b1; wen_a = bus.mem_addr;
                    wen_d = bus.mem_wdata;
                end
                if (mcnt == t_mdly) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = t_md;
                end
                mcnt++;
            end
            if (bus.resp_valid != '0) begin
                done = 1'b1;
                chk("resp_valid", {62'd0, bus.resp_valid}, {62'd0, onehot});
                chk("resp_data", {32'd0, bus.resp_data}, {32'd0, e_data});
                chk("resp_state", {62'd0, bus.resp_state}, {62'd0, e_state});
                chk("latency", 64'(cyc), 64'(e_lat));
            end
        end
        chk("resp_seen", {63'd0, done}, 64'd1);
        pend[w] = 1'b0;
        drive_req();
        idle_inputs();
        @(negedge CLK);
        chk("resp_one_cycle", {62'd0, bus.resp_valid}, 64'd0);
        chk("wb_access", {63'd0, saw_wen}, {63'd0, e_wb});
        chk("mem_read", {63'd0, saw_ren}, {63'd0, e_rd});
        chk("ren_wen_excl", {63'd0, saw_both}, 64'd0);
        if (e_wb) begin
            chk("wb_addr", {32'd0, wen_a}, {32'd0, a});
            chk("wb_data", {32'd0, wen_d}, {32'd0, e_data});
        end
        if (e_rd) chk("rd_addr", {32'd0, ren_a}, {32'd0, a});
        ptr = (w + 1) % N;
        if (!done) begin
            RST = 1'b1;
            @(negedge CLK);
            RST = 1'b0;
            ptr = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        bit used;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        idle_inputs();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; paddr[i] = '0; pwr[i] = 1'b0;
        end
        clear_scn();

        RST = 1'b1;
        repeat (2) @(negedge CLK);
        all_outs_zero("reset_outputs");
        RST = 1'b0;

        // Cache0 read, no sharers: memory fill, EXCLUSIVE.
        clear_scn();
        pend[0] = 1'b1; paddr[0] = 32'h100; pwr[0] = 1'b0;
        t_md = 32'hDEADBEEF; t_mdly = 1;
        run_txn(0);

        // Cache1 read, cache0 dirty: write-back then SHARED.
        clear_scn();
        pend[1] = 1'b1; paddr[1] = 32'h200; pwr[1] = 1'b0;
        t_hit[0] = 1'b1; t_dirty[0] = 1'b1; t_sd[0] = 32'h12345678;
        t_md = 32'hFFFF0000; t_mdly = 2; t_dly[0] = 1;
        run_txn(1);

        // Cache0 write, cache1 dirty: direct transfer, minimum latency.
        clear_scn();
        pend[0] = 1'b1; paddr[0] = 32'h300; pwr[0] = 1'b1;
        t_hit[1] = 1'b1; t_dirty[1] = 1'b1; t_sd[1] = 32'hA5A5A5A5;
        run_txn(0);

        // Reset in SNOOP with the snoop answer withheld.
        clear_scn();
        pend[0] = 1'b1; paddr[0] = 32'h400; pwr[0] = 1'b0;
        drive_req();
        @(negedge CLK);
        chk("rst_snoop_active", {62'd0, bus.snoop_req}, 64'd2);
        RST = 1'b1;
        pend[0] = 1'b0;
        drive_req();
        @(negedge CLK);
        all_outs_zero("rst_mid_outputs");
        RST = 1'b0;
        ptr = 0;
        repeat (2) begin
            @(negedge CLK);
            chk("rst_no_resp", {62'd0, bus.resp_valid}, 64'd0);
        end

        // Simultaneous requests: 0 then 1, pointer back at 0.
        clear_scn();
        pend[0] = 1'b1; paddr[0] = 32'h500; pwr[0] = 1'b0;
        pend[1] = 1'b1; paddr[1] = 32'h600; pwr[1] = 1'b0;
        t_md = 32'h11112222;
        run_txn(0);
        t_md = 32'h33334444;
        run_txn(1);
        pend[0] = 1'b1; pend[1] = 1'b1;
        t_md = 32'h55556666;
        run_txn(0);
        t_md = 32'h77778888;
        run_txn(1);

        // Clean sharer on a read miss.
        clear_scn();
        pend[1] = 1'b1; paddr[1] = 32'h700; pwr[1] = 1'b0;
        t_hit[0] = 1'b1; t_sd[0] = 32'h55AA55AA;
        t_md = 32'h0BADF00D; t_mdly = 2;
        run_txn(1);

        // Random traffic against the rule model.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1'b1;
                    paddr[i] = $urandom;
                    pwr[i]   = 1'($urandom_range(0, 1));
                end
            end
            if (rr_pick() < 0) begin
                w = $urandom_range(0, N - 1);
                pend[w]  = 1'b1;
                paddr[w] = $urandom;
                pwr[w]   = 1'($urandom_range(0, 1));
            end
            w = rr_pick();
            used = 1'b0;
            for (int i = 0; i < N; i++) begin
                t_hit[i]   = (i != w) && ($urandom_range(0, 1) == 1);
                t_dirty[i] = t_hit[i] && !used && ($urandom_range(0, 1) == 1);
                used       = used | t_dirty[i];
                t_sd[i]    = $urandom;
                t_dly[i]   = $urandom_range(0, 3);
            end
            t_md   = $urandom;
            t_mdly = $urandom_range(0, 3);
            run_txn(w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Parametrised snooping MESI bus controller between N private L1 data caches and the shared memory port. Serves one miss at a time.
- Arbitrates miss requests round-robin, snoops every other cache, and sources block data from a dirty owner, a clean sharer or memory.
- Returns the MESI end state to the requester, using the cc_end_state encoding: MODIFIED=0, EXCLUSIVE=1, SHARED=2, INVALID=3.
- Successor to the single-cache coherence interface: adds N-way arbitration, snoop handshake and write-back sequencing.

Parameters:
- N_CACHES, 2, number of attached caches (2..8).
- ADDR_W, 32, block address width.
- WORD_W, 32, data width; one word per transfer.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- req_valid  in  N_CACHES  miss request per cache; held until the matching resp_valid.
- req_write  in  N_CACHES  1 = write miss (needs ownership), 0 = read miss.
- req_addr  in  N_CACHES*ADDR_W  packed miss addresses; cache i occupies bits [i*ADDR_W +: ADDR_W].
- snoop_req  out  N_CACHES  snoop strobe to every non-requesting cache.
- snoop_addr  out  ADDR_W  winner's address.
- snoop_inv  out  1  snooped copies must go INVALID; when 0, hitting copies go SHARED.
- snoop_resp_valid  in  N_CACHES  snoop answered.
- snoop_hit  in  N_CACHES  cache holds the block.
- snoop_dirty  in  N_CACHES  cache holds the block MODIFIED.
- snoop_data  in  N_CACHES*WORD_W  packed snoop data, valid with snoop_resp_valid.
- resp_valid  out  N_CACHES  one-cycle completion pulse to the winner.
- resp_data  out  WORD_W  fill data.
- resp_state  out  2  MESI end state.
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  WORD_W  memory write data.
- mem_rdata  in  WORD_W  memory read data.
- mem_ready  in  1  memory access complete.

Behaviour:
- Reset: state IDLE, round-robin pointer = 0, all outputs 0. Reset mid-operation aborts the transaction; no resp_valid is issued.
- IDLE:
  - If any req_valid is set, pick the first requester at or after the pointer (modulo N_CACHES), latch its index, address and write bit, and go to SNOOP.
- SNOOP:
  - Hold snoop_req on all caches except the winner; snoop_addr = latched address; snoop_inv = latched write bit.
  - Stay until every snooped cache's snoop_resp_valid has been seen. Responses may arrive in different cycles and are latched per cache.
  - snoop_req drops the cycle after the last response is seen.
- DECIDE (one cycle), first match wins:
  - Dirty hit, read miss -> WB.
  - Dirty hit, write miss -> RESP; data = owner's snoop_data; state MODIFIED.
  - Clean hit, read miss -> MEMRD, or C2C when the optional feature is compiled in; state SHARED.
  - Clean hit, write miss -> MEMRD; state MODIFIED.
  - No hit -> MEMRD; state EXCLUSIVE for a read, MODIFIED for a write.
  - More than one dirty hit is a protocol error: the lowest dirty index is used, and an assertion fires in simulation.
- WB:
  - mem_wen=1, mem_addr=latched address, mem_wdata=owner data, held until mem_ready.
  - Then RESP with the owner data and state SHARED.
- MEMRD:
  - mem_ren=1 until mem_ready; latch mem_rdata, then RESP.
- RESP:
  - resp_valid[winner]=1 for exactly one cycle with resp_data and resp_state.
  - Pointer becomes winner+1, wrapping N_CACHES-1 -> 0; then IDLE.
- mem_ren and mem_wen are never high together.
- A requester must deassert req_valid the cycle after resp_valid; a new request is not accepted until IDLE.
- Minimum latency, request to resp_valid: 4 cycles (IDLE, SNOOP, DECIDE, RESP) with zero-cycle snoop responses.
- With N_CACHES=1 there is nothing to snoop: SNOOP completes in one cycle with no hits.

Optional Feature:
- Macro: CC_CACHE_TO_CACHE_EN.
- Defined: a clean hit on a read miss goes to C2C, a one-cycle state that takes data from the lowest-index clean hitter's snoop_data and then goes to RESP with SHARED; no memory access.
- Undefined: the same case goes to MEMRD.

Test Plan:
- Cache0 read miss, addr 0x100, no snoop hits, mem_rdata 0xDEADBEEF -> mem_ren pulse; resp_valid[0] with data 0xDEADBEEF, state EXCLUSIVE.
- Cache1 read miss, addr 0x200; cache0 dirty hit with 0x12345678 -> mem_wen with wdata 0x12345678 at 0x200; resp_valid[1] with 0x12345678, SHARED; snoop_inv=0.
- Cache0 write miss, addr 0x300; cache1 dirty hit with 0xA5A5A5A5 -> snoop_inv=1; no memory access; resp_valid[0] with 0xA5A5A5A5, MODIFIED.
- Caches 0 and 1 request in the same cycle after reset -> cache0 served first, then cache1; pointer then 0 again.
- Clean hit on a read miss with data 0x55AA55AA, run with and without CC_CACHE_TO_CACHE_EN:
  - Defined: no mem_ren; resp 0x55AA55AA, SHARED.
  - Undefined: mem_ren asserted; resp = mem_rdata, SHARED.
- RST asserted during SNOOP with snoop_resp_valid withheld -> next cycle all outputs 0, no resp_valid; a fresh request completes normally afterwards.
